// File: rtl/ienc_pkg.sv
// Shared definitions for the instruction encoder: mnemonic codes, opcode and
// function-field constants, and the encoder result type.
package ienc_pkg;

    localparam int unsigned INSTR_W = 16;

    // Codes 13..15 are illegal and have no enumerator.
    typedef enum logic [3:0] {
        MnAnd  = 4'd0,
        MnOr   = 4'd1,
        MnXor  = 4'd2,
        MnAdd  = 4'd3,
        MnSub  = 4'd4,
        MnSll  = 4'd5,
        MnSra  = 4'd6,
        MnAddi = 4'd7,
        MnSubi = 4'd8,
        MnSlti = 4'd9,
        MnLw   = 4'd10,
        MnSw   = 4'd11,
        MnBeq  = 4'd12
    } mnem_e;

    localparam logic [3:0] OP_LOGIC = 4'b0000;
    localparam logic [3:0] OP_ARITH = 4'b0001;
    localparam logic [3:0] OP_SHIFT = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_SLTI  = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_BEQ   = 4'b1111;

    localparam logic [2:0] FUNCT_AND = 3'b000;
    localparam logic [2:0] FUNCT_OR  = 3'b001;
    localparam logic [2:0] FUNCT_XOR = 3'b010;
    localparam logic [2:0] FUNCT_ADD = 3'b000;
    localparam logic [2:0] FUNCT_SUB = 3'b001;
    localparam logic [2:0] FUNCT_SLL = 3'b000;
    localparam logic [2:0] FUNCT_SRA = 3'b001;

    typedef struct packed {
        logic               legal;
        logic [INSTR_W-1:0] word;
    } enc_t;

endpackage

// File: rtl/ienc_fifo.sv
// Synchronous FIFO buffering encoded instruction words.
// Ports: clk/rst_n (async active-low), flush (sync empty, wins over push/pop),
// push/wdata, pop/rdata (rdata shows the head word), full, empty.
module ienc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PtrW:0]    wrPtrQ, rdPtrQ;

    assign empty = (wrPtrQ == rdPtrQ);
    assign full  = (wrPtrQ[PtrW] != rdPtrQ[PtrW]) && (wrPtrQ[PtrW-1:0] == rdPtrQ[PtrW-1:0]);
    assign rdata = mem[rdPtrQ[PtrW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
        end else if (flush) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
        end else begin
            if (push && !full) wrPtrQ <= wrPtrQ + 1'b1;
            if (pop && !empty) rdPtrQ <= rdPtrQ + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem[wrPtrQ[PtrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes mnemonic+field requests into 16-bit instruction words and writes them
// sequentially into instruction memory over a req/gnt port.
// Ports: clk, rst_n (async active-low), clear (sync restart);
// request side in_valid/in_ready/in_mnem/in_rs/in_rt/in_rd/in_imm;
// memory side imem_req/imem_gnt/imem_addr/imem_wdata;
// status err_illegal, mem_full, words_wr.
// Build option: IENC_ILLEGAL_STOP_EN makes err_illegal sticky and blocks input
// until clear/reset; otherwise err_illegal is a one-cycle pulse.
module instr_encoder
    import ienc_pkg::*;
#(
    parameter int unsigned      ADDR_W     = 8,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_mnem,
    input  logic [2:0]         in_rs,
    input  logic [2:0]         in_rt,
    input  logic [2:0]         in_rd,
    input  logic [5:0]         in_imm,
    output logic               imem_req,
    input  logic               imem_gnt,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               err_illegal,
    output logic               mem_full,
    output logic [ADDR_W:0]    words_wr
);
    typedef enum logic [0:0] {StIdle, StReq} state_e;

    function automatic enc_t encodeInstr(logic [3:0] mnem, logic [2:0] rs, logic [2:0] rt,
                                         logic [2:0] rd, logic [5:0] imm);
        enc_t       e;
        logic [3:0] op;
        logic [2:0] funct;
        logic       isR;
        e.legal = 1'b1;
        op      = OP_LOGIC;
        funct   = FUNCT_AND;
        isR     = 1'b1;
        case (mnem)
            MnAnd:   funct = FUNCT_AND;
            MnOr:    funct = FUNCT_OR;
            MnXor:   funct = FUNCT_XOR;
            MnAdd:   begin op = OP_ARITH; funct = FUNCT_ADD; end
            MnSub:   begin op = OP_ARITH; funct = FUNCT_SUB; end
            MnSll:   begin op = OP_SHIFT; funct = FUNCT_SLL; end
            MnSra:   begin op = OP_SHIFT; funct = FUNCT_SRA; end
            MnAddi:  begin op = OP_ADDI;  isR = 1'b0; end
            MnSubi:  begin op = OP_SUBI;  isR = 1'b0; end
            MnSlti:  begin op = OP_SLTI;  isR = 1'b0; end
            MnLw:    begin op = OP_LW;    isR = 1'b0; end
            MnSw:    begin op = OP_SW;    isR = 1'b0; end
            MnBeq:   begin op = OP_BEQ;   isR = 1'b0; end
            default: e.legal = 1'b0;
        endcase
        e.word = isR ? {op, rs, rt, rd, funct} : {op, rs, rt, imm};
        return e;
    endfunction

    state_e              stateQ, stateD;
    logic [ADDR_W-1:0]   addrQ, addrD;
    logic [INSTR_W-1:0]  dataQ, dataD;
    logic [ADDR_W:0]     countQ, countD;
    logic                memFullQ, memFullD;
    logic                errQ, errD;

    enc_t                enc;
    logic                accept;
    logic                fifoPush, fifoPop, fifoFlush, fifoFull, fifoEmpty;
    logic [INSTR_W-1:0]  fifoRdata;

    ienc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) uFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifoFlush),
        .push  (fifoPush),
        .wdata (enc.word),
        .pop   (fifoPop),
        .rdata (fifoRdata),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_comb begin
        enc = encodeInstr(in_mnem, in_rs, in_rt, in_rd, in_imm);
`ifdef IENC_ILLEGAL_STOP_EN
        in_ready = rst_n & ~fifoFull & ~memFullQ & ~clear & ~errQ;
`else
        in_ready = rst_n & ~fifoFull & ~memFullQ & ~clear;
`endif
        accept   = in_valid & in_ready;
        fifoPush = accept & enc.legal;
    end

    always_comb begin
        stateD    = stateQ;
        addrD     = addrQ;
        dataD     = dataQ;
        countD    = countQ;
        memFullD  = memFullQ;
        fifoPop   = 1'b0;
        fifoFlush = 1'b0;
`ifdef IENC_ILLEGAL_STOP_EN
        errD = errQ | (accept & ~enc.legal);
`else
        errD = accept & ~enc.legal;
`endif
        if (clear) begin
            // Restart wins over everything, including a grant in this cycle.
            stateD    = StIdle;
            addrD     = BASE_ADDR;
            dataD     = '0;
            countD    = '0;
            memFullD  = 1'b0;
            errD      = 1'b0;
            fifoFlush = 1'b1;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (!fifoEmpty && !memFullQ) begin
                        fifoPop = 1'b1;
                        dataD   = fifoRdata;
                        stateD  = StReq;
                    end
                end
                StReq: begin
                    if (imem_gnt) begin
                        countD = countQ + 1'b1;
                        if (addrQ == '1) begin
                            // Top of memory: no wrap, drop whatever is still buffered.
                            memFullD  = 1'b1;
                            fifoFlush = 1'b1;
                            stateD    = StIdle;
                        end else begin
                            addrD = addrQ + 1'b1;
                            if (!fifoEmpty) begin
                                fifoPop = 1'b1;
                                dataD   = fifoRdata;
                            end else begin
                                stateD = StIdle;
                            end
                        end
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIdle;
            addrQ    <= BASE_ADDR;
            dataQ    <= '0;
            countQ   <= '0;
            memFullQ <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            addrQ    <= addrD;
            dataQ    <= dataD;
            countQ   <= countD;
            memFullQ <= memFullD;
            errQ     <= errD;
        end
    end

    assign imem_req    = (stateQ == StReq);
    assign imem_addr   = addrQ;
    assign imem_wdata  = dataQ;
    assign err_illegal = errQ;
    assign mem_full    = memFullQ;
    assign words_wr    = countQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic, checked against a queue-based reference model of the write stream.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_mnem = '0;
    logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [5:0]  in_imm = '0;
    logic        imem_gnt = 1'b0;
    logic        in_ready, imem_req, err_illegal, mem_full;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [8:0]  words_wr;

    // Second instance with a 4-word address space for the end-of-memory case.
    logic        sClear = 1'b0, sValid = 1'b0, sGnt = 1'b1;
    logic [3:0]  sMnem = 4'd3;
    logic [2:0]  sRs = 3'd1, sRt = 3'd2, sRd = 3'd3;
    logic [5:0]  sImm = '0;
    logic        sReady, sReq, sErr, sFull;
    logic [1:0]  sAddr;
    logic [15:0] sWdata;
    logic [2:0]  sWords;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .err_illegal(err_illegal), .mem_full(mem_full),
        .words_wr(words_wr)
    );

    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(2'd0)) dutSmall (
        .clk(clk), .rst_n(rst_n), .clear(sClear), .in_valid(sValid), .in_ready(sReady),
        .in_mnem(sMnem), .in_rs(sRs), .in_rt(sRt), .in_rd(sRd), .in_imm(sImm),
        .imem_req(sReq), .imem_gnt(sGnt), .imem_addr(sAddr), .imem_wdata(sWdata),
        .err_illegal(sErr), .mem_full(sFull), .words_wr(sWords)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference encoding from the mnemonic table, by plain field arithmetic.
    int opTab[13] = '{0, 0, 0, 1, 1, 2, 2, 9, 10, 11, 12, 13, 15};
    int fnTab[13] = '{0, 1, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};

    function automatic int refEncode(int mn, int rs, int rt, int rd, int imm);
        if (mn <= 6) return opTab[mn] * 4096 + rs * 512 + rt * 64 + rd * 8 + fnTab[mn];
        return opTab[mn] * 4096 + rs * 512 + rt * 64 + imm;
    endfunction

    int expQ[$];
    int expAddr = 0;
    int wrCount = 0;
    int gntMode = 0;  // 0 low, 1 high, 2 random

    always @(posedge clk) begin
        #1;
        case (gntMode)
            0:       imem_gnt = 1'b0;
            1:       imem_gnt = 1'b1;
            default: imem_gnt = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Write-stream monitor: every granted write must be the oldest expected word.
    logic        prevReq = 1'b0, prevGnt = 1'b0, prevClr = 1'b0;
    logic [7:0]  prevAddr = '0;
    logic [15:0] prevData = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && prevReq && !prevGnt && !prevClr) begin
                checkVal("hold_addr", imem_addr, prevAddr);
                checkVal("hold_data", imem_wdata, prevData);
            end
            if (clear) begin
                expQ.delete();
                expAddr = 0;
                wrCount = 0;
            end else if (imem_req && imem_gnt) begin
                if (expQ.size() == 0) begin
                    checkVal("write_expected", expQ.size() > 0, 1);
                end else begin
                    checkVal("wdata", imem_wdata, expQ.pop_front());
                    checkVal("waddr", imem_addr, expAddr);
                    expAddr++;
                    wrCount++;
                end
            end
        end
        prevReq  = imem_req;
        prevGnt  = imem_gnt;
        prevClr  = clear;
        prevAddr = imem_addr;
        prevData = imem_wdata;
    end

    int sWrites = 0;
    always @(negedge clk) begin
        if (rst_n && sReq && sGnt) begin
            checkVal("small_addr", sAddr, sWrites);
            checkVal("small_data", sWdata, 32'h1298);
            sWrites++;
        end
    end

    // Called and returns at posedge+1; the accept edge is the posedge just passed.
    task automatic sendReq(input int mn, input int rs, input int rt, input int rd, input int imm);
        bit ok = 0;
        in_valid = 1'b1;
        in_mnem  = mn[3:0];
        in_rs    = rs[2:0];
        in_rt    = rt[2:0];
        in_rd    = rd[2:0];
        in_imm   = imm[5:0];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkVal("accept_timeout", 0, 1);
        else if (mn < 13) expQ.push_back(refEncode(mn, rs, rt, rd, imm));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !imem_req) break;
        end
        checkVal("drain_queue", expQ.size(), 0);
        checkVal("drain_idle", imem_req, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int mn;
        int sAcc;
        bit sawReq;

        // Reset values
        repeat (2) @(negedge clk);
        checkVal("rst_ready", in_ready, 0);
        checkVal("rst_req", imem_req, 0);
        checkVal("rst_addr", imem_addr, 0);
        checkVal("rst_wdata", imem_wdata, 0);
        checkVal("rst_err", err_illegal, 0);
        checkVal("rst_full", mem_full, 0);
        checkVal("rst_words", words_wr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // ADD 1,2,3 -> 0x1298 @0, request two cycles after accept
        gntMode = 1;
        sendReq(3, 1, 2, 3, 0);
        @(negedge clk);
        checkVal("lat_n1_req", imem_req, 0);
        @(negedge clk);
        checkVal("lat_n2_req", imem_req, 1);
        @(posedge clk);
        #1;
        waitDrain();

        // LW then BEQ, in order from address 0
        doClear();
        sendReq(10, 2, 5, 0, 63);
        sendReq(12, 0, 0, 0, 32);
        waitDrain();
        checkVal("lw_beq_words", words_wr, 2);

        // Grant held low: four buffered plus one in flight, then in_ready drops
        gntMode = 0;
        doClear();
        for (int i = 0; i < 5; i++)
            sendReq($urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 63));
        @(negedge clk);
        checkVal("stall_ready", in_ready, 0);
        checkVal("stall_req", imem_req, 1);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        fork
            sendReq(7, 4, 5, 0, 21);
            begin
                repeat (2) @(posedge clk);
                gntMode = 1;
            end
        join
        waitDrain();
        checkVal("stall_words", words_wr, wrCount);
        checkVal("stall_words6", words_wr, 6);

        // Illegal mnemonic
        sendReq(14, 1, 1, 1, 1);
        @(negedge clk);
        checkVal("illegal_err", err_illegal, 1);
        checkVal("illegal_noreq", imem_req, 0);
        @(negedge clk);
`ifdef IENC_ILLEGAL_STOP_EN
        checkVal("illegal_sticky", err_illegal, 1);
        checkVal("illegal_block", in_ready, 0);
`else
        checkVal("illegal_pulse", err_illegal, 0);
        checkVal("illegal_ready", in_ready, 1);
`endif
        checkVal("illegal_noreq2", imem_req, 0);
        @(posedge clk);
        #1;
        doClear();
        @(negedge clk);
        checkVal("clr_err", err_illegal, 0);
        checkVal("clr_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Clear during REQ with three words buffered and a grant pending
        gntMode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) sendReq(4, i, i + 1, i + 2, 0);
        @(negedge clk);
        checkVal("pre_clr_req", imem_req, 1);
        gntMode = 1;
        @(posedge clk);
        #1;
        doClear();
        @(negedge clk);
        checkVal("clr_req", imem_req, 0);
        checkVal("clr_addr", imem_addr, 0);
        checkVal("clr_words", words_wr, 0);
        checkVal("clr_wdata", imem_wdata, 0);
        sawReq = 0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req) sawReq = 1;
        end
        checkVal("clr_flushed", sawReq, 0);
        @(posedge clk);
        #1;

        // Randomized traffic with random grants
        gntMode = 2;
        for (int i = 0; i < 40; i++) begin
`ifdef IENC_ILLEGAL_STOP_EN
            mn = $urandom_range(0, 12);
`else
            mn = $urandom_range(0, 15);
`endif
            sendReq(mn, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 63));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        waitDrain();
        checkVal("rand_words", words_wr, wrCount);

        // End of address space on the 2-bit instance
        sValid = 1'b1;
        sAcc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sValid && sReady) sAcc++;
            @(posedge clk);
            #1;
            if (sAcc >= 5) sValid = 1'b0;
        end
        @(negedge clk);
        checkVal("small_accepts", sAcc, 5);
        checkVal("small_writes", sWrites, 4);
        checkVal("small_full", sFull, 1);
        checkVal("small_words", sWords, 4);
        checkVal("small_ready", sReady, 0);
        checkVal("small_req", sReq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
